// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: captures a WIDTH-bit word and shifts it out one bit per
// enabled clock, then pulses done. Defining PISO_PARITY_EN appends an even-parity bit to each frame.
module piso_shift_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(WIDTH + 2);
  localparam logic [CntW-1:0] FrameLenC = CntW'(FrameLen);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  count_q;
  logic             sdo_q;
  logic             sdo_valid_q;
  logic             done_q;
`ifdef PISO_PARITY_EN
  logic             parity_q;
  localparam logic [CntW-1:0] ParityPos = CntW'(WIDTH);
`endif

  // The shift register always holds the not-yet-sent bits aligned to the output end.
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

  assign first_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
  assign next_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign load_rest  = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
  assign shift_rest = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      count_q     <= '0;
      sdo_q       <= 1'b0;
      sdo_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (clr) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      count_q     <= '0;
      sdo_q       <= 1'b0;
      sdo_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (en) begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (load_valid) begin
            shreg_q     <= load_rest;
            sdo_q       <= first_bit;
            sdo_valid_q <= 1'b1;
            count_q     <= CntW'(1);
            state_q     <= StShift;
`ifdef PISO_PARITY_EN
            parity_q    <= ^data_in;
`endif
          end
        end
        StShift: begin
          if (count_q != FrameLenC) begin
            count_q <= count_q + CntW'(1);
`ifdef PISO_PARITY_EN
            if (count_q == ParityPos) begin
              sdo_q <= parity_q;
            end else begin
              sdo_q   <= next_bit;
              shreg_q <= shift_rest;
            end
`else
            sdo_q   <= next_bit;
            shreg_q <= shift_rest;
`endif
          end else begin
            sdo_q       <= 1'b0;
            sdo_valid_q <= 1'b0;
            done_q      <= 1'b1;
            count_q     <= '0;
            state_q     <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign load_ready = (state_q == StIdle);
  assign busy       = (state_q == StShift) || (state_q == StDone);
  assign sdo        = sdo_q;
  assign sdo_valid  = sdo_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an MSB-first and an LSB-first instance driven with shared stimulus,
// checked by a directed vector table, hand-written corner sequences and a queue-based model.
module tb_piso_shift_tx;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         en;
  logic [W-1:0] data_in;
  logic         load_valid;

  logic load_ready_m, sdo_m, sdo_valid_m, busy_m, done_m;
  logic load_ready_l, sdo_l, sdo_valid_l, busy_l, done_l;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .en         (en),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready_m),
    .sdo        (sdo_m),
    .sdo_valid  (sdo_valid_m),
    .busy       (busy_m),
    .done       (done_m)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .en         (en),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready_l),
    .sdo        (sdo_l),
    .sdo_valid  (sdo_valid_l),
    .busy       (busy_l),
    .done       (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: frame is a queue of bits still to be sent.
  typedef enum int {MIdle, MSend, MDone} mmode_e;
  mmode_e mmode;
  bit     mq_m[$];
  bit     mq_l[$];
  bit     msdo_m, msdo_l, mvalid, mdone;

  function automatic void model_reset();
    mmode  = MIdle;
    mq_m.delete();
    mq_l.delete();
    msdo_m = 1'b0;
    msdo_l = 1'b0;
    mvalid = 1'b0;
    mdone  = 1'b0;
  endfunction

  function automatic void model_edge(input logic c, input logic e, input logic l,
                                     input logic [W-1:0] d);
    if (c) begin
      model_reset();
    end else if (e) begin
      case (mmode)
        MIdle: begin
          mdone = 1'b0;
          if (l) begin
            mq_m.delete();
            mq_l.delete();
            for (int i = 0; i < W; i++) begin
              mq_m.push_back(d[W-1-i]);
              mq_l.push_back(d[i]);
            end
`ifdef PISO_PARITY_EN
            mq_m.push_back(^d);
            mq_l.push_back(^d);
`endif
            msdo_m = mq_m.pop_front();
            msdo_l = mq_l.pop_front();
            mvalid = 1'b1;
            mmode  = MSend;
          end
        end
        MSend: begin
          if (mq_m.size() > 0) begin
            msdo_m = mq_m.pop_front();
            msdo_l = mq_l.pop_front();
          end else begin
            msdo_m = 1'b0;
            msdo_l = 1'b0;
            mvalid = 1'b0;
            mdone  = 1'b1;
            mmode  = MDone;
          end
        end
        default: begin
          mdone = 1'b0;
          mmode = MIdle;
        end
      endcase
    end
  endfunction

  function automatic logic [4:0] model_out(input bit lsb);
    logic idle;
    idle = (mmode == MIdle);
    return {idle, !idle, mvalid, lsb ? msdo_l : msdo_m, mdone};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {ready,busy,valid,sdo,done}=%b expected %b at %0t",
               name, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_m();
    return {load_ready_m, busy_m, sdo_valid_m, sdo_m, done_m};
  endfunction

  function automatic logic [4:0] dut_l();
    return {load_ready_l, busy_l, sdo_valid_l, sdo_l, done_l};
  endfunction

  // Drive inputs, take one clock edge, then compare both instances with the model.
  task automatic step(input logic c, input logic e, input logic l, input logic [W-1:0] d);
    clr        = c;
    en         = e;
    load_valid = l;
    data_in    = d;
    @(posedge clk);
    model_edge(c, e, l, d);
    #1;
    check("model_msb", dut_m(), model_out(1'b0));
    check("model_lsb", dut_l(), model_out(1'b1));
  endtask

  typedef struct {
    logic         clr;
    logic         en;
    logic         lv;
    logic [W-1:0] data;
    logic [4:0]   exp;  // MSB-first instance {ready,busy,valid,sdo,done}
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [W-1:0] w;

    // 0xA5 MSB-first with a 3-cycle enable gap after bit 2, load_valid held during the frame.
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA5, 5'b01110});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h11, 5'b01100});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h22, 5'b01110});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h33, 5'b01110});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h44, 5'b01110});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h55, 5'b01110});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h66, 5'b01100});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h77, 5'b01100});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h88, 5'b01110});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h99, 5'b01100});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hAA, 5'b01110});
`ifdef PISO_PARITY_EN
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hBB, 5'b01100});
`endif
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hCC, 5'b01001});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'hDD, 5'b01001});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hEE, 5'b10000});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h80, 5'b01110});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 5'b01100});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'hFF, 5'b10000});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hFF, 5'b10000});

    rst_n      = 1'b0;
    clr        = 1'b0;
    en         = 1'b0;
    load_valid = 1'b0;
    data_in    = '0;
    model_reset();
    #7;
    check("reset_msb", dut_m(), 5'b10000);
    check("reset_lsb", dut_l(), 5'b10000);
    #3;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].lv, vecs[i].data);
      check($sformatf("vec%0d", i), dut_m(), vecs[i].exp);
    end

    // LSB-first 0xC5 -> 1,0,1,0,0,0,1,1 on the LSB instance.
    w = 8'hC5;
    for (int k = 0; k < W; k++) begin
      step(1'b0, 1'b1, (k == 0), w);
      check($sformatf("lsb_c5_bit%0d", k), {sdo_valid_l, sdo_l, done_l}, {1'b1, w[k], 1'b0});
    end
`ifdef PISO_PARITY_EN
    step(1'b0, 1'b1, 1'b0, '0);
`endif
    step(1'b0, 1'b1, 1'b0, '0);
    check("lsb_c5_done", {sdo_valid_l, sdo_l, done_l}, 3'b001);
    step(1'b0, 1'b1, 1'b0, '0);

    // Abort 0xFF with clr after bit 4: no done, ready again immediately.
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("clr_abort", dut_m(), 5'b10000);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      check("clr_no_done", {done_m, done_l}, 2'b00);
    end

    // Asynchronous reset between edges mid-frame, then a fresh 0x3C frame.
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_msb", dut_m(), 5'b10000);
    check("async_rst_lsb", dut_l(), 5'b10000);
    #1;
    rst_n = 1'b1;
    w = 8'h3C;
    for (int k = 0; k < W; k++) begin
      step(1'b0, 1'b1, (k == 0), w);
      check($sformatf("post_rst_bit%0d", k), {sdo_valid_m, sdo_m}, {1'b1, w[W-1-k]});
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, '0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 75), ($urandom_range(99) < 50),
           W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
